// File: rtl/calc_input_conditioner_pkg.sv
// Shared definitions for the calculator input conditioner: button indices and debounce FSM states.
package calc_input_conditioner_pkg;

    // Button bit positions on btn_in / btn_level / btn_press
    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_L = 1;
    localparam int unsigned BTN_R = 2;
    localparam int unsigned BTN_U = 3;
    localparam int unsigned BTN_D = 4;

    // Per-button debounce state
    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } btn_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce FSM and stability counter, producing a clean level and a press pulse.
module btn_debounce_ch
    import calc_input_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    btn_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Metastability chain; bit 0 takes the raw pin
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // Next-state: any reversal during a RISE/FALL run restarts from the settled state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_RISE;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_RISE: begin
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_HIGH;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_FALL;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_FALL: begin
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_LOW;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/calc_input_conditioner.sv
// Board input front-end for the calculator: debounced buttons with press pulses, synchronised switches.
module calc_input_conditioner
    import calc_input_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN           = 5,
    parameter int unsigned SW_W            = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [SW_W-1:0]  sw_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [SW_W-1:0]  sw_sync
);

    logic [SYNC_STAGES-1:0][SW_W-1:0] sw_q;

    // Switch synchroniser; stage 0 takes the raw bus, last stage drives sw_sync
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_q <= '0;
        end else begin
            sw_q <= {sw_q[SYNC_STAGES-2:0], sw_in};
        end
    end

    assign sw_sync = sw_q[SYNC_STAGES-1];

    // Independent debounce channel per button
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (btn_in[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

endmodule

// File: tb/tb_calc_input_conditioner.sv
// Scoreboard bench for calc_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_calc_input_conditioner;

    logic        clk;
    logic        rst_n;
    logic [4:0]  btn_in;
    logic [15:0] sw_in;
    logic [4:0]  btn_level;
    logic [4:0]  btn_press;
    logic [15:0] sw_sync;

    calc_input_conditioner #(
        .N_BTN          (5),
        .SW_W           (16),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .sw_in    (sw_in),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .sw_sync  (sw_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count of rising edges seen so far; entries are tagged with the edge after which they hold
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int          cyc;
        logic [4:0]  lvl;
        logic [4:0]  prs;
        logic        chk;
        logic [15:0] sw;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   base        = 0;

    // Queue expectations for relative edges k0..k1 of the current test
    function automatic void push_range(int k0, int k1, logic [4:0] lvl, logic [4:0] prs,
                                       logic chk, logic [15:0] sw, string name);
        for (int k = k0; k <= k1; k++) begin
            exp_t e;
            e.cyc  = base + k;
            e.lvl  = lvl;
            e.prs  = prs;
            e.chk  = chk;
            e.sw   = sw;
            e.name = name;
            sb.push_back(e);
        end
    endfunction

    // Start a new test: relative edge 0 is the next rising edge
    task automatic new_base();
        base = edge_n + 1;
    endtask

    // Move to the negedge from which a change is first sampled on relative edge k
    task automatic at_k(int k);
        while (edge_n < base + k - 1) @(negedge clk);
    endtask

    // Monitor: compare every queued expectation on the negedge after its edge
    exp_t m;
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= edge_n) begin
            m = sb.pop_front();
            vectors++;
            if (m.cyc != edge_n || btn_level !== m.lvl || btn_press !== m.prs ||
                (m.chk && sw_sync !== m.sw)) begin
                miscompares++;
                $display("FAIL %s edge %0d (due %0d): level=%h press=%h sw=%h, expected level=%h press=%h sw=%h%s",
                         m.name, edge_n, m.cyc, btn_level, btn_press, sw_sync,
                         m.lvl, m.prs, m.sw, m.chk ? "" : " (sw not checked)");
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        btn_in = 5'h1F;
        sw_in  = 16'hFFFF;

        // Reset: everything held at zero while rst_n is low
        base = 1;
        push_range(0, 1, 5'h00, 5'h00, 1'b1, 16'h0000, "reset");
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (btn_level !== 5'h00 || btn_press !== 5'h00 || sw_sync !== 16'h0000) begin
            miscompares++;
            $display("FAIL direct reset: level=%h press=%h sw=%h", btn_level, btn_press, sw_sync);
        end
        rst_n  = 1'b1;
        btn_in = 5'h00;
        sw_in  = 16'h0000;
        new_base();
        push_range(0, 3, 5'h00, 5'h00, 1'b1, 16'h0000, "post_reset_idle");
        at_k(4);

        // Press btnd: pulse on edge 6, release 12 cycles later drops level on edge 18
        new_base();
        push_range(0, 1,   5'h00, 5'h00, 1'b0, 16'h0000, "btnd_wait");
        push_range(2, 5,   5'h00, 5'h00, 1'b1, 16'h354A, "btnd_wait_sw");
        push_range(6, 6,   5'h10, 5'h10, 1'b1, 16'h354A, "btnd_press");
        push_range(7, 17,  5'h10, 5'h00, 1'b1, 16'h354A, "btnd_hold");
        push_range(18, 21, 5'h00, 5'h00, 1'b1, 16'h354A, "btnd_release");
        at_k(0);
        btn_in = 5'h10;
        sw_in  = 16'h354A;
        at_k(12);
        vectors++;
        if (btn_level !== 5'h10 || btn_press !== 5'h00 || sw_sync !== 16'h354A) begin
            miscompares++;
            $display("FAIL direct btnd_hold: level=%h press=%h sw=%h", btn_level, btn_press, sw_sync);
        end
        btn_in = 5'h00;
        at_k(22);

        // Glitch on btnc shorter than the debounce window
        new_base();
        push_range(0, 12, 5'h00, 5'h00, 1'b1, 16'h354A, "glitch");
        at_k(0);
        btn_in = 5'h01;
        at_k(3);
        btn_in = 5'h00;
        at_k(13);

        // Bouncing btnr: final rise at k4 -> pulse at k10; fall at k14 -> level low at k20
        new_base();
        push_range(0, 9,   5'h00, 5'h00, 1'b1, 16'h354A, "bounce_wait");
        push_range(10, 10, 5'h04, 5'h04, 1'b1, 16'h354A, "bounce_press");
        push_range(11, 19, 5'h04, 5'h00, 1'b1, 16'h354A, "bounce_hold");
        push_range(20, 23, 5'h00, 5'h00, 1'b1, 16'h354A, "bounce_release");
        at_k(0); btn_in = 5'h04;
        at_k(1); btn_in = 5'h00;
        at_k(2); btn_in = 5'h04;
        at_k(3); btn_in = 5'h00;
        at_k(4); btn_in = 5'h04;
        at_k(14);
        vectors++;
        if (btn_level !== 5'h04 || btn_press !== 5'h00) begin
            miscompares++;
            $display("FAIL direct bounce_hold: level=%h press=%h", btn_level, btn_press);
        end
        btn_in = 5'h00;
        at_k(24);

        // Simultaneous btnc + btnd: both pulses on the same edge
        new_base();
        push_range(0, 5,   5'h00, 5'h00, 1'b1, 16'h354A, "simul_wait");
        push_range(6, 6,   5'h11, 5'h11, 1'b1, 16'h354A, "simul_press");
        push_range(7, 13,  5'h11, 5'h00, 1'b1, 16'h354A, "simul_hold");
        push_range(14, 17, 5'h00, 5'h00, 1'b1, 16'h354A, "simul_release");
        at_k(0);
        btn_in = 5'h11;
        at_k(8);
        btn_in = 5'h00;
        at_k(18);

        // Reset mid-count on btnu: no pulse, then re-debounce from first edge with rst_n=1 (k5) -> pulse at k11
        new_base();
        push_range(0, 2,   5'h00, 5'h00, 1'b1, 16'h354A, "rstmid_count");
        push_range(3, 5,   5'h00, 5'h00, 1'b1, 16'h0000, "rstmid_reset");
        push_range(6, 10,  5'h00, 5'h00, 1'b1, 16'h354A, "rstmid_redebounce");
        push_range(11, 11, 5'h08, 5'h08, 1'b1, 16'h354A, "rstmid_press");
        push_range(12, 19, 5'h08, 5'h00, 1'b1, 16'h354A, "rstmid_hold");
        push_range(20, 23, 5'h00, 5'h00, 1'b1, 16'h354A, "rstmid_release");
        at_k(0);
        btn_in = 5'h08;
        at_k(3);
        rst_n = 1'b0;
        at_k(5);
        rst_n = 1'b1;
        at_k(14);
        vectors++;
        if (btn_level !== 5'h08 || btn_press !== 5'h00) begin
            miscompares++;
            $display("FAIL direct rstmid_hold: level=%h press=%h", btn_level, btn_press);
        end
        btn_in = 5'h00;
        at_k(24);

        // Drain with a bounded wait; anything left over never got checked
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        while (sb.size() != 0) begin
            m = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: expectation for edge %0d never checked, expected level=%h press=%h",
                     m.name, m.cyc, m.lvl, m.prs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares == 0) $display("PASS");
        else                  $display("FAIL");
        $finish;
    end

endmodule
